// File: rtl/spi_monitor_bridge.sv
// SPI slave that snapshots the CPU bus on chip-select and shifts it out LSB-first with a sequence byte,
// while receiving an input-signal word. SPI pins are oversampled and synchronised into CLK_IN.
module spi_monitor_bridge #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 16,
  parameter int OUT_SIG_WIDTH = 4,
  parameter int IN_SIG_WIDTH  = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     CLK_IN,
  input  logic                     RESET_IN,
  input  logic                     SPICLK_IN,
  input  logic                     SPISI_IN,
  input  logic                     SPISS_IN,
  input  logic [ADDR_WIDTH-1:0]    ADDR_IN,
  input  logic [DATA_WIDTH-1:0]    DATA_IN,
  input  logic [OUT_SIG_WIDTH-1:0] OUTPUT_SIGNAL_IN,
  output logic [IN_SIG_WIDTH-1:0]  INPUT_SIGNAL,
  output logic                     SPISO,
  output logic                     SPISO_OE,
  output logic                     BUSY,
  output logic                     FRAME_DONE,
  output logic [7:0]               SEQ
);

  localparam int PAY_BITS  = ADDR_WIDTH + DATA_WIDTH + OUT_SIG_WIDTH;
  localparam int PAY_BYTES = (PAY_BITS + 7) / 8;
  localparam int TX_BITS   = 8 * (PAY_BYTES + 1);
  localparam int RX_BITS   = 8 * ((IN_SIG_WIDTH + 7) / 8);
  localparam int CW        = $clog2(TX_BITS + 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  logic [SYNC_STAGES-1:0]  r_sck_sync, r_si_sync, r_ss_sync;
  logic                    r_sck_q, r_ss_q;
  state_t                  r_state;
  logic [TX_BITS-1:0]      r_tx;
  logic [RX_BITS-1:0]      r_rx;
  logic [CW-1:0]           r_cnt;
  logic                    r_rx_done;
  logic [IN_SIG_WIDTH-1:0] r_in_sig;
  logic                    r_spiso, r_oe, r_busy, r_frame_done;
  logic [7:0]              r_seq;

  logic                    w_sck, w_si, w_ss;
  logic                    w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;
  logic [TX_BITS-1:0]      w_load;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_si       = r_si_sync[SYNC_STAGES-1];
  assign w_ss       = r_ss_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_q;
  assign w_sck_fall = ~w_sck & r_sck_q;
  assign w_ss_fall  = ~w_ss & r_ss_q;
  assign w_ss_rise  = w_ss & ~r_ss_q;

  // Pad bits between the payload and the sequence byte stay zero.
  always_comb begin
    w_load = '0;
    w_load[PAY_BITS-1:0]  = {OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN};
    w_load[TX_BITS-1 -: 8] = r_seq;
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r_sck_sync <= '0;
      r_si_sync  <= '0;
      r_ss_sync  <= '1;
      r_sck_q    <= 1'b0;
      r_ss_q     <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], SPICLK_IN};
      r_si_sync  <= {r_si_sync[SYNC_STAGES-2:0], SPISI_IN};
      r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], SPISS_IN};
      r_sck_q    <= w_sck;
      r_ss_q     <= w_ss;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r_state      <= ST_IDLE;
      r_tx         <= '0;
      r_rx         <= '0;
      r_cnt        <= '0;
      r_rx_done    <= 1'b0;
      r_in_sig     <= '0;
      r_spiso      <= 1'b0;
      r_oe         <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_seq        <= '0;
    end else begin
      r_frame_done <= 1'b0;
      // Word is applied once, the cycle after the RX count is reached, even if SS rises then.
      if (r_state == ST_ACTIVE && !r_rx_done && r_cnt >= CW'(RX_BITS)) begin
        r_in_sig  <= r_rx[IN_SIG_WIDTH-1:0];
        r_rx_done <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            r_tx      <= w_load;
            r_spiso   <= w_load[0];
            r_oe      <= 1'b1;
            r_busy    <= 1'b1;
            r_cnt     <= '0;
            r_rx      <= '0;
            r_rx_done <= 1'b0;
            r_state   <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (w_ss_rise) begin
            r_spiso <= 1'b0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            if (r_cnt == CW'(TX_BITS)) begin
              r_frame_done <= 1'b1;
              r_seq        <= r_seq + 8'd1;
            end
          end else if (w_sck_rise) begin
            if (r_cnt < CW'(RX_BITS))
              r_rx <= {w_si, r_rx[RX_BITS-1:1]};
            if (r_cnt != CW'(TX_BITS))
              r_cnt <= r_cnt + 1'b1;
          end else if (w_sck_fall) begin
            r_tx    <= {1'b0, r_tx[TX_BITS-1:1]};
            r_spiso <= r_tx[1];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign INPUT_SIGNAL = r_in_sig;
  assign SPISO        = r_spiso;
  assign SPISO_OE     = r_oe;
  assign BUSY         = r_busy;
  assign FRAME_DONE   = r_frame_done;
  assign SEQ          = r_seq;

endmodule

// File: tb/tb_spi_monitor_bridge.sv
// Directed bench for spi_monitor_bridge: default parameters, 56-bit TX frame, 8-bit RX word.
module tb_spi_monitor_bridge;

  localparam int HALF = 6;

  logic        CLK_IN = 1'b0;
  logic        RESET_IN;
  logic        SPICLK_IN, SPISI_IN, SPISS_IN;
  logic [23:0] ADDR_IN;
  logic [15:0] DATA_IN;
  logic [3:0]  OUTPUT_SIGNAL_IN;
  logic [3:0]  INPUT_SIGNAL;
  logic        SPISO, SPISO_OE, BUSY, FRAME_DONE;
  logic [7:0]  SEQ;

  int n_vec = 0;
  int n_err = 0;

  spi_monitor_bridge dut (
    .CLK_IN(CLK_IN), .RESET_IN(RESET_IN), .SPICLK_IN(SPICLK_IN), .SPISI_IN(SPISI_IN),
    .SPISS_IN(SPISS_IN), .ADDR_IN(ADDR_IN), .DATA_IN(DATA_IN),
    .OUTPUT_SIGNAL_IN(OUTPUT_SIGNAL_IN), .INPUT_SIGNAL(INPUT_SIGNAL), .SPISO(SPISO),
    .SPISO_OE(SPISO_OE), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .SEQ(SEQ)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_IN);
    #1;
  endtask

  // One mode-0 bit: MISO is sampled just before the rising edge.
  task automatic spi_bit(input logic mosi, output logic miso);
    SPISI_IN = mosi;
    tick(HALF);
    miso = SPISO;
    SPICLK_IN = 1'b1;
    tick(HALF);
    SPICLK_IN = 1'b0;
  endtask

  task automatic ss_begin;
    SPISS_IN = 1'b0;
    tick(HALF);
  endtask

  task automatic ss_end(output int pulses);
    tick(HALF);
    SPISS_IN = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (FRAME_DONE === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset;
    RESET_IN = 1'b0; SPICLK_IN = 1'b0; SPISI_IN = 1'b0; SPISS_IN = 1'b1;
    ADDR_IN = 24'h123456; DATA_IN = 16'hBEEF; OUTPUT_SIGNAL_IN = 4'hA;
    tick(3);
    n_vec++; if (INPUT_SIGNAL !== 4'h0) begin n_err++; $display("FAIL reset_insig got=%h exp=0", INPUT_SIGNAL); end
    n_vec++; if (SPISO !== 1'b0) begin n_err++; $display("FAIL reset_spiso got=%b exp=0", SPISO); end
    n_vec++; if (SPISO_OE !== 1'b0) begin n_err++; $display("FAIL reset_oe got=%b exp=0", SPISO_OE); end
    n_vec++; if (SEQ !== 8'h00) begin n_err++; $display("FAIL reset_seq got=%h exp=00", SEQ); end
    n_vec++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    n_vec++; if (FRAME_DONE !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", FRAME_DONE); end
    RESET_IN = 1'b1;
    tick(4);
  endtask

  task automatic test_frame;
    logic [55:0] got;
    logic [7:0]  mosi = 8'h05;
    logic        b;
    int          pulses;
    ss_begin();
    n_vec++; if (SPISO_OE !== 1'b1 || BUSY !== 1'b1) begin n_err++; $display("FAIL frame_select got oe=%b busy=%b exp 1 1", SPISO_OE, BUSY); end
    for (int i = 0; i < 56; i++) begin
      spi_bit(i < 8 ? mosi[i] : 1'b0, b);
      got[i] = b;
      if (i == 6) begin
        n_vec++; if (INPUT_SIGNAL !== 4'h0) begin n_err++; $display("FAIL frame_insig_bit7 got=%h exp=0", INPUT_SIGNAL); end
      end
      if (i == 7) begin
        n_vec++; if (INPUT_SIGNAL !== 4'h5) begin n_err++; $display("FAIL frame_insig_bit8 got=%h exp=5", INPUT_SIGNAL); end
      end
    end
    n_vec++; if (got !== 56'h000ABEEF123456) begin n_err++; $display("FAIL frame_miso got=%h exp=000abeef123456", got); end
    ss_end(pulses);
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL frame_done_pulses got=%0d exp=1", pulses); end
    n_vec++; if (SEQ !== 8'h01) begin n_err++; $display("FAIL frame_seq got=%h exp=01", SEQ); end
    n_vec++; if (SPISO_OE !== 1'b0 || BUSY !== 1'b0 || SPISO !== 1'b0) begin n_err++; $display("FAIL frame_idle got oe=%b busy=%b so=%b exp 0 0 0", SPISO_OE, BUSY, SPISO); end
  endtask

  // Bits after the RX word are all ones and must not disturb INPUT_SIGNAL.
  task automatic test_back_to_back;
    logic [55:0] got;
    logic [7:0]  mosi = 8'h03;
    logic        b;
    int          pulses;
    ss_begin();
    for (int i = 0; i < 56; i++) begin
      spi_bit(i < 8 ? mosi[i] : 1'b1, b);
      got[i] = b;
    end
    n_vec++; if (got !== 56'h010ABEEF123456) begin n_err++; $display("FAIL b2b_miso got=%h exp=010abeef123456", got); end
    ss_end(pulses);
    n_vec++; if (pulses != 1) begin n_err++; $display("FAIL b2b_done_pulses got=%0d exp=1", pulses); end
    n_vec++; if (SEQ !== 8'h02) begin n_err++; $display("FAIL b2b_seq got=%h exp=02", SEQ); end
    n_vec++; if (INPUT_SIGNAL !== 4'h3) begin n_err++; $display("FAIL b2b_insig got=%h exp=3", INPUT_SIGNAL); end
  endtask

  task automatic test_snapshot_stable;
    logic [55:0] got;
    logic [7:0]  mosi = 8'h05;
    logic        b;
    int          pulses;
    ss_begin();
    for (int i = 0; i < 56; i++) begin
      spi_bit(i < 8 ? mosi[i] : 1'b0, b);
      got[i] = b;
      if (i == 3) begin ADDR_IN = 24'hFFFFFF; DATA_IN = 16'h0000; end
    end
    n_vec++; if (got !== 56'h020ABEEF123456) begin n_err++; $display("FAIL snap_miso got=%h exp=020abeef123456", got); end
    ss_end(pulses);
    n_vec++; if (SEQ !== 8'h03) begin n_err++; $display("FAIL snap_seq got=%h exp=03", SEQ); end
    ADDR_IN = 24'h123456; DATA_IN = 16'hBEEF;
  endtask

  task automatic test_abort;
    logic [7:0] mosi = 8'h0F;
    logic       b;
    int         pulses;
    ss_begin();
    for (int i = 0; i < 5; i++) spi_bit(mosi[i], b);
    ss_end(pulses);
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL abort_done_pulses got=%0d exp=0", pulses); end
    n_vec++; if (SEQ !== 8'h03) begin n_err++; $display("FAIL abort_seq got=%h exp=03", SEQ); end
    n_vec++; if (INPUT_SIGNAL !== 4'h5) begin n_err++; $display("FAIL abort_insig got=%h exp=5", INPUT_SIGNAL); end
    n_vec++; if (SPISO_OE !== 1'b0 || BUSY !== 1'b0) begin n_err++; $display("FAIL abort_idle got oe=%b busy=%b exp 0 0", SPISO_OE, BUSY); end
  endtask

  task automatic test_reset_midframe;
    logic [55:0] got;
    logic [7:0]  mosi = 8'h0C;
    logic        b;
    int          pulses;
    ss_begin();
    for (int i = 0; i < 20; i++) spi_bit(i < 8 ? mosi[i] : 1'b0, b);
    n_vec++; if (INPUT_SIGNAL !== 4'hC) begin n_err++; $display("FAIL rst_pre_insig got=%h exp=c", INPUT_SIGNAL); end
    #2 RESET_IN = 1'b0;
    #1;
    n_vec++; if (INPUT_SIGNAL !== 4'h0 || SEQ !== 8'h00) begin n_err++; $display("FAIL rst_mid_regs got insig=%h seq=%h exp 0 00", INPUT_SIGNAL, SEQ); end
    n_vec++; if (SPISO_OE !== 1'b0 || BUSY !== 1'b0 || SPISO !== 1'b0 || FRAME_DONE !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_outs got oe=%b busy=%b so=%b done=%b exp 0 0 0 0", SPISO_OE, BUSY, SPISO, FRAME_DONE);
    end
    SPISS_IN = 1'b1; SPICLK_IN = 1'b0;
    tick(3);
    RESET_IN = 1'b1;
    tick(4);
    mosi = 8'h09;
    ss_begin();
    for (int i = 0; i < 56; i++) begin
      spi_bit(i < 8 ? mosi[i] : 1'b0, b);
      got[i] = b;
    end
    n_vec++; if (got[55:48] !== 8'h00) begin n_err++; $display("FAIL rst_next_seqbyte got=%h exp=00", got[55:48]); end
    n_vec++; if (got !== 56'h000ABEEF123456) begin n_err++; $display("FAIL rst_next_miso got=%h exp=000abeef123456", got); end
    ss_end(pulses);
    n_vec++; if (pulses != 1 || SEQ !== 8'h01) begin n_err++; $display("FAIL rst_next_done got pulses=%0d seq=%h exp 1 01", pulses, SEQ); end
    n_vec++; if (INPUT_SIGNAL !== 4'h9) begin n_err++; $display("FAIL rst_next_insig got=%h exp=9", INPUT_SIGNAL); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_snapshot_stable();
    test_abort();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_monitor_bridge.md
Name: spi_monitor_bridge

Overview:
System-clock-domain SPI slave monitor: generalised successor of the bus snapshot monitor. On chip-select it captures the CPU bus state (address, data, output signals) atomically and shifts it out LSB-first, together with a frame sequence byte. Concurrently it receives an input-signal word, which is applied only on a complete transfer. SPI pins are oversampled on CLK_IN, so all outputs are synchronous to the one system clock.

Parameters:
ADDR_WIDTH, 24, width of ADDR_IN
DATA_WIDTH, 16, width of DATA_IN
OUT_SIG_WIDTH, 4, width of OUTPUT_SIGNAL_IN
IN_SIG_WIDTH, 4, width of INPUT_SIGNAL (1..32)
SYNC_STAGES, 2, synchroniser depth on SPICLK_IN/SPISI_IN/SPISS_IN (>=2)

Ports:
CLK_IN  in  1  system clock, sole clock
RESET_IN  in  1  reset, asynchronous, active-low
SPICLK_IN  in  1  SPI clock, mode 0 (idle low)
SPISI_IN  in  1  MOSI
SPISS_IN  in  1  chip select, active-low
ADDR_IN  in  ADDR_WIDTH  bus address to snapshot
DATA_IN  in  DATA_WIDTH  bus data to snapshot
OUTPUT_SIGNAL_IN  in  OUT_SIG_WIDTH  CPU output signals to snapshot
INPUT_SIGNAL  out  IN_SIG_WIDTH  signals driven back to the CPU side
SPISO  out  1  MISO data
SPISO_OE  out  1  MISO output enable (high while selected)
BUSY  out  1  frame in progress
FRAME_DONE  out  1  one-CLK pulse on completed frame
SEQ  out  8  completed-frame counter

Behaviour:
- Derived: PAY_BITS = ADDR_WIDTH+DATA_WIDTH+OUT_SIG_WIDTH; PAY_BYTES = ceil(PAY_BITS/8); TX_BITS = 8*(PAY_BYTES+1); RX_BITS = 8*ceil(IN_SIG_WIDTH/8).
- TX frame, LSB first: {SEQ, zero pad, OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN}; ADDR_IN[0] is the first bit.
- Reset (RESET_IN low, async): INPUT_SIGNAL=0, SPISO=0, SPISO_OE=0, BUSY=0, FRAME_DONE=0, SEQ=0, state IDLE, synchronisers cleared to SS high/SCK low.
- Synchronised pins feed edge detectors: ss_fall, ss_rise, sck_rise, sck_fall. SPI timing requirement: SCK high and low phases each >= SYNC_STAGES+2 CLK periods; SS setup before first SCK rise is also >= SYNC_STAGES+2 CLK periods.
- IDLE: SCK edges are ignored. On ss_fall: latch the snapshot from the inputs sampled in that CLK; load the TX shift register; clear the bit counter and RX shift register; SPISO = bit 0; SPISO_OE=1; BUSY=1; go ACTIVE. SCK edges detected in the same CLK as ss_fall are ignored.
- ACTIVE, sck_rise: shift SPISI into the RX register (LSB first, MSB-in/right-shift); increment the bit counter. The counter saturates at TX_BITS.
- ACTIVE, sck_fall: shift the TX register right with zero fill and drive SPISO from its bit 0. Once TX_BITS bits are exhausted, SPISO = 0.
- RX apply: in the CLK after the counter reaches RX_BITS, INPUT_SIGNAL <= RX[IN_SIG_WIDTH-1:0] (upper bits of the word are ignored). This happens once per frame. Later MOSI bits are ignored.
- ACTIVE, ss_rise: SPISO=0, SPISO_OE=0, BUSY=0, go IDLE.
  - If counter == TX_BITS: FRAME_DONE pulses for 1 CLK and SEQ increments (wraps 255->0).
  - Otherwise (aborted frame): no pulse and SEQ is unchanged. INPUT_SIGNAL changes only if RX_BITS were already reached.
- ss_rise takes priority over an SCK edge detected in the same CLK; that edge is discarded.
- Snapshot inputs changing mid-frame do not affect the shifted data.
- Reset mid-frame aborts immediately to reset values. The master must deselect and reselect.

Test Plan:
- Reset with defaults -> INPUT_SIGNAL=0x0, SPISO=0, SPISO_OE=0, SEQ=0, BUSY=0.
- ADDR_IN=0x123456, DATA_IN=0xBEEF, OUTPUT_SIGNAL_IN=0xA; 56-clock frame with MOSI first byte 0x05 -> MISO bytes 56 34 12 EF BE 0A 00; INPUT_SIGNAL=0x5 after the 8th SCK rise; FRAME_DONE pulse at SS high; SEQ=1.
- Repeat the frame -> last MISO byte 0x01; SEQ=2.
- Change ADDR_IN to 0xFFFFFF after 4 SCK cycles -> MISO still reports 0x123456.
- Abort after 5 SCK cycles with MOSI 0x0F -> INPUT_SIGNAL unchanged, no FRAME_DONE, SEQ unchanged, SPISO_OE=0.
- Assert RESET_IN at bit 20 -> all outputs at reset values immediately; the next full frame's last MISO byte is 0x00.
